// File: rtl/key_schedule_dec.sv
// DES round-key generator: loads PC1(key), then streams the 16 PC2 subkeys
// over a valid/ready handshake in forward (encrypt) or reverse (decrypt) order.
module key_schedule_dec (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key,
  input  logic        start,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Table entries number bits from 1 = MSB, hence the (width - entry) index.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      src    = 6'(64 - PC1[i]);
      dst    = 6'(55 - i);
      r[dst] = k[src];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  src;
    logic [5:0]  dst;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      src    = 6'(56 - PC2[i]);
      dst    = 6'(47 - i);
      r[dst] = cd[src];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  logic [1:0]  state;
  logic [27:0] c, d;
  logic        dec;
  logic        two;
  logic [55:0] loaded;

  // Next-step shift is 1 after transfers 0, 7 and 14; 2 otherwise. Same in both directions.
  assign two    = !(round == 4'd0 || round == 4'd7 || round == 4'd14);
  assign loaded = pc1(key);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      round <= '0;
      dec   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          c     <= loaded[55:28];
          d     <= loaded[27:0];
          dec   <= decrypt;
          round <= '0;
          state <= LOAD;
        end
        // Decrypt starts from C16||D16, which equals C0||D0 (total shift is 28).
        LOAD: begin
          if (!dec) begin
            c <= rotl(c, 1'b0);
            d <= rotl(d, 1'b0);
          end
          state <= RUN;
        end
        RUN: if (subkey_ready) begin
          if (round == 4'd15) begin
            state <= DONE;
          end else begin
            round <= round + 4'd1;
            c     <= dec ? rotr(c, two) : rotl(c, two);
            d     <= dec ? rotr(d, two) : rotl(d, two);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    subkey_valid = (state == RUN);
    subkey       = subkey_valid ? pc2({c, d}) : 48'd0;
    busy         = (state == LOAD) || (state == RUN);
    done         = (state == DONE);
  end

endmodule
